// File: rtl/proc_pc_rf.sv
// Fetch PC plus 32 x XLEN integer register file for the single-cycle RV64 subset core.
// Optional debug read port enabled by defining PROC_PC_RF_DEBUG_EN.
module proc_pc_rf #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          XLEN     = 64,
  parameter int          NREG     = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [31:0]     new_pc,
  input  logic            pc_src,
  output logic [31:0]     pc,
  input  logic            reg_write,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
`ifdef PROC_PC_RF_DEBUG_EN
  ,
  input  logic [4:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_rdata
`endif
);

  logic [31:0]     r_pc;
  logic [31:0]     w_pc_next;
  logic [XLEN-1:0] r_regs [NREG];
  logic            w_wr_en;

  // x0 is hard-wired to zero regardless of what the storage holds
  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx,
                                               input logic [XLEN-1:0] val);
    if (idx == 5'd0) begin
      return {XLEN{1'b0}};
    end else begin
      return val;
    end
  endfunction

  // Next PC: redirect target word-aligned, otherwise sequential (wraps mod 2^32)
  always_comb begin
    w_pc_next = r_pc + 32'd4;
    if (pc_src) begin
      w_pc_next = {new_pc[31:2], 2'b00};
    end else begin
      w_pc_next = r_pc + 32'd4;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pc <= PC_RESET;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign pc      = r_pc;
  assign w_wr_en = reg_write && (rd != 5'd0);

  // Register storage; writes to x0 are discarded
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else if (w_wr_en) begin
      r_regs[rd] <= wdata;
    end
  end

  // Combinational read ports, no bypass: a same-cycle write shows up after the edge
  always_comb begin
    rdata1 = read_reg(rs1, r_regs[rs1]);
    rdata2 = read_reg(rs2, r_regs[rs2]);
  end

`ifdef PROC_PC_RF_DEBUG_EN
  // Debug read port, independent of the functional read ports
  always_comb begin
    dbg_rdata = read_reg(dbg_sel, r_regs[dbg_sel]);
  end
`endif

endmodule

// File: tb/tb_proc_pc_rf.sv
// Directed self-checking bench for proc_pc_rf: reset, PC sequencing/redirect/wrap,
// register write/read semantics, x0 handling and asynchronous reset.
module tb_proc_pc_rf;

  localparam int XLEN = 64;

  logic            clk;
  logic            nrst;
  logic [31:0]     new_pc;
  logic            pc_src;
  logic [31:0]     pc;
  logic            reg_write;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
`ifdef PROC_PC_RF_DEBUG_EN
  logic [4:0]      dbg_sel;
  logic [XLEN-1:0] dbg_rdata;
`endif

  int n_checks;
  int n_errors;

  proc_pc_rf #(
    .PC_RESET (32'h0000_0000),
    .XLEN     (XLEN),
    .NREG     (32)
  ) u_dut (
    .clk       (clk),
    .nrst      (nrst),
    .new_pc    (new_pc),
    .pc_src    (pc_src),
    .pc        (pc),
    .reg_write (reg_write),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .wdata     (wdata),
    .rdata1    (rdata1),
    .rdata2    (rdata2)
`ifdef PROC_PC_RF_DEBUG_EN
    ,
    .dbg_sel   (dbg_sel),
    .dbg_rdata (dbg_rdata)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  localparam logic [63:0] PAT_A = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] PAT_B = 64'h0F0F_1234_A5A5_0001;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    nrst      = 1'b0;
    new_pc    = 32'd0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    rs1       = 5'd0;
    rs2       = 5'd0;
    rd        = 5'd0;
    wdata     = 64'd0;
`ifdef PROC_PC_RF_DEBUG_EN
    dbg_sel   = 5'd0;
`endif

    // Reset held across an edge
    @(negedge clk);
    check_eq("pc_in_reset", {32'd0, pc}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0];
      rs2 = 5'd31 - i[4:0];
      #1;
      check_eq("rd1_reset", rdata1, 64'd0);
      check_eq("rd2_reset", rdata2, 64'd0);
    end
    nrst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_eq("pc_seq", {32'd0, pc}, 64'(4 * k));
    end

    // Redirects, low bits of target dropped
    pc_src = 1'b1; new_pc = 32'h0000_0040;
    @(negedge clk);
    check_eq("pc_redir_40", {32'd0, pc}, 64'h40);
    new_pc = 32'h0000_0103;
    @(negedge clk);
    check_eq("pc_redir_103", {32'd0, pc}, 64'h100);
    pc_src = 1'b0;
    @(negedge clk);
    check_eq("pc_after_redir", {32'd0, pc}, 64'h104);

    // Write x5 while reading it: old value before edge, new after
    reg_write = 1'b1; rd = 5'd5; wdata = PAT_A; rs1 = 5'd5; rs2 = 5'd5;
    #1;
    check_eq("rdw_old", rdata1, 64'd0);
    @(negedge clk);
    check_eq("rdw_new_rd1", rdata1, PAT_A);
    check_eq("rdw_new_rd2", rdata2, PAT_A);

    // Write x6, read distinct ports
    rd = 5'd6; wdata = PAT_B;
    @(negedge clk);
    rs2 = 5'd6;
    #1;
    check_eq("x5_rd1", rdata1, PAT_A);
    check_eq("x6_rd2", rdata2, PAT_B);

    // x0 writes discarded
    rd = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF; rs1 = 5'd0;
    @(negedge clk);
    check_eq("x0_zero", rdata1, 64'd0);
    check_eq("x6_kept", rdata2, PAT_B);

    // reg_write=0 leaves x7 untouched
    reg_write = 1'b0; rd = 5'd7; wdata = 64'd5; rs1 = 5'd7;
    @(negedge clk);
    check_eq("x7_nowrite", rdata1, 64'd0);
`ifdef PROC_PC_RF_DEBUG_EN
    dbg_sel = 5'd5;
    #1;
    check_eq("dbg_x5", dbg_rdata, PAT_A);
    check_eq("dbg_no_disturb", rdata1, 64'd0);
`endif

    // PC wrap
    pc_src = 1'b1; new_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    check_eq("pc_top", {32'd0, pc}, 64'hFFFF_FFFC);
    pc_src = 1'b0;
    @(negedge clk);
    check_eq("pc_wrap", {32'd0, pc}, 64'd0);

    // Write x3=9, then asynchronous reset mid-cycle
    reg_write = 1'b1; rd = 5'd3; wdata = 64'd9;
    @(negedge clk);
    reg_write = 1'b0; rs1 = 5'd3; rs2 = 5'd5;
    #1;
    check_eq("x3_written", rdata1, 64'd9);
    check_eq("pc_pre_rst", {32'd0, pc}, 64'd4);
    #1;
    nrst = 1'b0;
    #1;
    check_eq("async_pc", {32'd0, pc}, 64'd0);
    check_eq("async_x3", rdata1, 64'd0);
    check_eq("async_x5", rdata2, 64'd0);

    // Writes ignored while in reset
    reg_write = 1'b1; rd = 5'd3; wdata = 64'd7;
    @(posedge clk);
    #1;
    check_eq("rst_nowrite", rdata1, 64'd0);
    check_eq("rst_pc_hold", {32'd0, pc}, 64'd0);
`ifdef PROC_PC_RF_DEBUG_EN
    check_eq("dbg_rst", dbg_rdata, 64'd0);
`endif
    reg_write = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check_eq("pc_post_rst", {32'd0, pc}, 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
